rd_responder: RTL and testbench

Target-side counterpart of the read-initiator FSM (`go`/`rd`/`ds`/`ws` handshake). It accepts a read strobe and address from the initiator, inserts a programmable number of wait states, and signals readiness by releasing `ws`. It then holds read data stable until the initiator acknowledges with `ds`. Data comes from a small internal register file written through a simple write port. The block sits on the target side of the read bus, one responder per initiator.

---
 rtl/rd_responder_if.sv | 23 ++
 rtl/rd_responder.sv | 129 ++++++++++++
 tb/tb_rd_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rd_responder_if.sv
// -----------------------------------------------------------------------------
// rd_responder_if
// Read-bus bundle between a read initiator and its target-side responder.
//   rd    : read strobe, held high for the whole transaction (initiator)
//   addr  : read address, valid while rd is high          (initiator)
//   ds    : data-strobe acknowledge                        (initiator)
//   ws    : wait-state flag, 1 = data not ready            (responder)
//   rdata : read data, valid while ws is low               (responder)
// Modports: master = initiator side, slave = responder side.
// -----------------------------------------------------------------------------
interface rd_responder_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          rd;
  logic [AW-1:0] addr;
  logic          ds;
  logic          ws;
  logic [DW-1:0] rdata;

  modport master (output rd, addr, ds, input ws, rdata);
  modport slave  (input rd, addr, ds, output ws, rdata);
endinterface

// File: rtl/rd_responder.sv
// -----------------------------------------------------------------------------
// rd_responder
// Target side of the go/rd/ds/ws read handshake. Accepts a read, waits a
// programmable number of cycles, presents data with ws low and holds it until
// the initiator acknowledges with ds. Data comes from a small register file
// written through an independent write port.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   bus       : read bus (slave modport): rd, addr, ds in; ws, rdata out
//   cfg_wait  : wait states, sampled only when a read is accepted
//   we/waddr/wdata : register-file write port
//   xfer_cnt  : completed-read counter, wraps
//   err       : sticky protocol-error flag
// -----------------------------------------------------------------------------
module rd_responder #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int WAIT_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  rd_responder_if.slave     bus,
  input  logic [WAIT_W-1:0] cfg_wait,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, READY, DONE} state_t;

  state_t            state_reg;
  logic [AW-1:0]     raddr_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              ws_reg;
  logic [DW-1:0]     rdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;

  // Register file, no reset so it maps onto block RAM.
  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // ds is only legal while data is presented. The address must stay put
  // while the read is live; once rd drops the initiator may move it freely.
  logic ds_err;
  logic addr_err;
  assign ds_err   = bus.ds && (state_reg != READY);
  assign addr_err = bus.rd && (bus.addr != raddr_reg) &&
                    ((state_reg == BUSY) || (state_reg == READY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      raddr_reg    <= '0;
      wait_cnt_reg <= '0;
      ws_reg       <= 1'b1;
      rdata_reg    <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (ds_err || addr_err) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          ws_reg <= 1'b1;
          if (bus.rd) begin
            raddr_reg    <= bus.addr;
            wait_cnt_reg <= cfg_wait;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.rd) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg != '0) begin
            wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
          end else begin
            // Non-blocking read: a write to raddr on this same edge is not
            // seen, the old word is returned.
            rdata_reg <= mem[raddr_reg];
            ws_reg    <= 1'b0;
            state_reg <= READY;
          end
        end
        READY: begin
          // rdata_reg is not reloaded here, so writes during READY do not
          // disturb the presented data.
          if (bus.ds) begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            ws_reg    <= 1'b1;
            state_reg <= DONE;
          end else if (!bus.rd) begin
            ws_reg    <= 1'b1;
            state_reg <= IDLE;
          end
        end
        DONE: begin
          ws_reg <= 1'b1;
          if (!bus.rd) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          ws_reg <= 1'b1;
`ifdef SYNTHESIS
          state_reg <= IDLE;
`else
          state_reg <= state_t'('x);
`endif
        end
      endcase
    end
  end

  assign bus.ws    = ws_reg;
  assign bus.rdata = rdata_reg;
  assign xfer_cnt  = cnt_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_rd_responder.sv
module tb_rd_responder;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int WAIT_W = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [WAIT_W-1:0] cfg_wait;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              err;

  rd_responder_if #(.DW(DW), .AW(AW)) bus ();

  rd_responder #(.DW(DW), .AW(AW), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cfg_wait (cfg_wait),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .xfer_cnt (xfer_cnt),
    .err      (err)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp  = '0;
  logic          ws_prev  = 1'b1;
  int            exp_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops the expected word when ws falls, then checks it stays
  // stable for every cycle ws remains low.
  always @(negedge clk) begin
    if (bus.ws === 1'b0) begin
      if (ws_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_unexpected: got %0h expected none", bus.rdata);
        end else begin
          cur_exp = exp_q.pop_front();
          check("rdata", 32'(bus.rdata), 32'(cur_exp));
          $display("read data %0h (expected %0h)", bus.rdata, cur_exp);
        end
      end else begin
        check("rdata_hold", 32'(bus.rdata), 32'(cur_exp));
      end
    end
    ws_prev = (bus.ws !== 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // Raise rd, let the accept edge pass, then scramble cfg_wait to show it
  // is only sampled at acceptance.
  task automatic start_read(input logic [AW-1:0] a, input logic [WAIT_W-1:0] n);
    bus.rd = 1'b1; bus.addr = a; cfg_wait = n;
    tick();
    cfg_wait = ~n;
  endtask

  // Continue from the accept edge; ws must fall after edge k+N+1,
  // i.e. the (N+2)-th edge after rd rose.
  task automatic wait_ready(input int n, input string name);
    int cyc = 1;
    while (bus.ws !== 1'b0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(n + 2));
  endtask

  task automatic finish_read(input string name);
    bus.ds = 1'b1; bus.rd = 1'b0;
    tick();
    bus.ds = 1'b0;
    exp_cnt = (exp_cnt + 1) % (2**CNT_W);
    check({name, "_ws_after_ds"}, 32'(bus.ws), 32'(1));
    check({name, "_xfer_cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [WAIT_W-1:0] n,
                         input logic [DW-1:0] d, input string name);
    exp_q.push_back(d);
    start_read(a, n);
    wait_ready(int'(n), name);
    finish_read(name);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ws"}, 32'(bus.ws), 32'(1));
    check({name, "_rdata"}, 32'(bus.rdata), 32'(0));
    check({name, "_xfer_cnt"}, 32'(xfer_cnt), 32'(0));
    check({name, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    rst = 1'b1; bus.rd = 1'b0; bus.ds = 1'b0; bus.addr = '0;
    cfg_wait = '0; we = 1'b0; waddr = '0; wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    wr(4'd3, 8'hA5); wr(4'd7, 8'h3C); wr(4'd2, 8'h11); wr(4'd5, 8'h5A);

    // Basic read and wait states (including the N=7 maximum).
    do_read(4'd3, 3'd0, 8'hA5, "basic");
    check("basic_err", 32'(err), 32'(0));
    do_read(4'd7, 3'd5, 8'h3C, "wait5");
    do_read(4'd5, 3'd7, 8'h5A, "wait7");

    // Abort in BUSY.
    start_read(4'd3, 3'd3);
    tick(); tick();
    bus.rd = 1'b0;
    tick();
    check("abort_busy_ws", 32'(bus.ws), 32'(1));
    check("abort_busy_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    do_read(4'd3, 3'd0, 8'hA5, "after_abort_busy");

    // Abort in READY.
    exp_q.push_back(8'h3C);
    start_read(4'd7, 3'd2);
    wait_ready(2, "abort_ready");
    bus.rd = 1'b0;
    tick();
    check("abort_ready_ws", 32'(bus.ws), 32'(1));
    check("abort_ready_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    do_read(4'd7, 3'd1, 8'h3C, "after_abort_ready");

    // Collision: write on the BUSY->READY edge, then again during READY.
    exp_q.push_back(8'h11);
    start_read(4'd2, 3'd0);
    we = 1'b1; waddr = 4'd2; wdata = 8'h22;
    wait_ready(0, "collision");
    we = 1'b0;
    we = 1'b1; wdata = 8'h33;
    tick();
    we = 1'b0;
    tick();
    finish_read("collision");
    do_read(4'd2, 3'd0, 8'h33, "collision_readback");

    // Protocol error: ds in IDLE, sticky across a good read.
    bus.ds = 1'b1;
    tick();
    bus.ds = 1'b0;
    check("err_set", 32'(err), 32'(1));
    do_read(4'd5, 3'd0, 8'h5A, "err_sticky");
    check("err_sticky", 32'(err), 32'(1));

    // Reset while in READY; register file survives.
    exp_q.push_back(8'hA5);
    start_read(4'd3, 3'd1);
    wait_ready(1, "rst_ready");
    rst = 1'b1; bus.rd = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check_reset_vals("rst_ready");
    do_read(4'd7, 3'd0, 8'h3C, "mem_kept7");
    do_read(4'd2, 3'd0, 8'h33, "mem_kept2");

    // Counter wrap: 17 reads from reset on a 4-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      do_read(4'd3, 3'd0, 8'hA5, "wrap");
    end
    check("wrap_cnt", 32'(xfer_cnt), 32'(1));
    check("wrap_err", 32'(err), 32'(0));

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
